// File: rtl/psk_mod_stream.sv
// rtl/psk_mod_stream.sv - serial-bit to QPSK/BPSK modulator, SPS samples per symbol, optional PSK_DIFF_ENC_EN differential encoding
module psk_mod_stream #(
   parameter int W   = 8,
   parameter int SPS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mode,
   input  logic                bit_in,
   input  logic                bit_valid,
   output logic                bit_ready,
   input  logic signed [W-1:0] cos_in,
   input  logic signed [W-1:0] sin_in,
   output logic                out_valid,
   output logic signed [W:0]   mod_out,
   output logic                sym_start,
   output logic                underrun
);
   localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);
   localparam logic signed [W+1:0] SUM_MAX = (W+2)'((1 << W) - 1);
   localparam logic signed [W+1:0] SUM_MIN = ~SUM_MAX;

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;
   state_t state_q, state_d;

   logic             col_cnt_q, col_cnt_d, col_bi_q, col_bi_d;
   logic             pend_full_q, pend_full_d, pend_bi_q, pend_bi_d;
   logic             pend_bq_q, pend_bq_d, pend_mode_q, pend_mode_d;
   logic             act_si_q, act_si_d, act_sq_q, act_sq_d, act_mode_q, act_mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d, sym_start_q, sym_start_d;
   logic             underrun_q, underrun_d;
   logic signed [W:0] mod_out_q, mod_out_d;
   logic             accept, load, sym_last;
   logic signed [W+1:0] cos_x, sin_x, term_i, term_q, sum;
`ifdef PSK_DIFF_ENC_EN
   logic [1:0] phase_q, phase_d, gray_idx;
   logic       bsign_q, bsign_d;
`endif

   assign bit_ready = !pend_full_q;
   assign accept    = bit_valid && !pend_full_q;
   assign sym_last  = (cnt_q == CNT_LAST);
   assign out_valid = out_valid_q;
   assign mod_out   = mod_out_q;
   assign sym_start = sym_start_q;
   assign underrun  = underrun_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: leave RUN only when a symbol ends with nothing pending
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pend_full_q) state_d = S_RUN;
         S_RUN:   if (sym_last && !pend_full_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Collector: a QPSK symbol waits for its second bit; BPSK completes on the first.
   // Load and accept never coincide on pend_full, so both are honoured independently.
   always_comb begin
      col_cnt_d   = col_cnt_q;
      col_bi_d    = col_bi_q;
      pend_full_d = pend_full_q;
      pend_bi_d   = pend_bi_q;
      pend_bq_d   = pend_bq_q;
      pend_mode_d = pend_mode_q;
      if (load) pend_full_d = 1'b0;
      if (accept) begin
         if (col_cnt_q) begin
            pend_full_d = 1'b1;
            pend_bi_d   = col_bi_q;
            pend_bq_d   = bit_in;
            pend_mode_d = 1'b0;
            col_cnt_d   = 1'b0;
         end else if (mode) begin
            pend_full_d = 1'b1;
            pend_bi_d   = bit_in;
            pend_bq_d   = 1'b0;
            pend_mode_d = 1'b1;
         end else begin
            col_cnt_d = 1'b1;
            col_bi_d  = bit_in;
         end
      end
   end

   // Sample arithmetic in W+2 bits, then clip to the W+1 signed output range
   always_comb begin
      cos_x  = {{2{cos_in[W-1]}}, cos_in};
      sin_x  = {{2{sin_in[W-1]}}, sin_in};
      term_i = act_si_q ? -cos_x : cos_x;
      term_q = act_mode_q ? '0 : (act_sq_q ? -sin_x : sin_x);
      sum    = term_i + term_q;
   end

   // Output logic: symbol load, counter, registered sample and status flags
   always_comb begin
      load        = 1'b0;
      cnt_d       = '0;
      act_si_d    = act_si_q;
      act_sq_d    = act_sq_q;
      act_mode_d  = act_mode_q;
      out_valid_d = 1'b0;
      sym_start_d = 1'b0;
      underrun_d  = 1'b0;
      mod_out_d   = '0;
`ifdef PSK_DIFF_ENC_EN
      phase_d  = phase_q;
      bsign_d  = bsign_q;
      gray_idx = {pend_bq_q, pend_bi_q ^ pend_bq_q};
`endif
      case (state_q)
         S_IDLE: load = pend_full_q;
         S_RUN: begin
            out_valid_d = 1'b1;
            sym_start_d = (cnt_q == '0);
            underrun_d  = sym_last && !pend_full_q;
            cnt_d       = sym_last ? '0 : cnt_q + 1'b1;
            load        = sym_last && pend_full_q;
            if (sum > SUM_MAX)      mod_out_d = SUM_MAX[W:0];
            else if (sum < SUM_MIN) mod_out_d = SUM_MIN[W:0];
            else                    mod_out_d = sum[W:0];
         end
         default: load = 1'b0;
      endcase
      if (load) begin
         act_mode_d = pend_mode_q;
`ifdef PSK_DIFF_ENC_EN
         if (pend_mode_q) begin
            bsign_d  = bsign_q ^ pend_bi_q;
            act_si_d = bsign_d;
            act_sq_d = 1'b0;
         end else begin
            phase_d  = phase_q + gray_idx;
            act_si_d = phase_d[1] ^ phase_d[0];
            act_sq_d = phase_d[1];
         end
`else
         act_si_d = pend_bi_q;
         act_sq_d = pend_bq_q;
`endif
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         col_cnt_q   <= 1'b0;
         col_bi_q    <= 1'b0;
         pend_full_q <= 1'b0;
         pend_bi_q   <= 1'b0;
         pend_bq_q   <= 1'b0;
         pend_mode_q <= 1'b0;
         act_si_q    <= 1'b0;
         act_sq_q    <= 1'b0;
         act_mode_q  <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         sym_start_q <= 1'b0;
         underrun_q  <= 1'b0;
         mod_out_q   <= '0;
      end else begin
         col_cnt_q   <= col_cnt_d;
         col_bi_q    <= col_bi_d;
         pend_full_q <= pend_full_d;
         pend_bi_q   <= pend_bi_d;
         pend_bq_q   <= pend_bq_d;
         pend_mode_q <= pend_mode_d;
         act_si_q    <= act_si_d;
         act_sq_q    <= act_sq_d;
         act_mode_q  <= act_mode_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         sym_start_q <= sym_start_d;
         underrun_q  <= underrun_d;
         mod_out_q   <= mod_out_d;
      end
   end

`ifdef PSK_DIFF_ENC_EN
   // Differential phase / BPSK sign state, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= 2'd0;
         bsign_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         bsign_q <= bsign_d;
      end
   end
`endif

endmodule

// File: tb/tb_psk_mod_stream.sv
// tb/tb_psk_mod_stream.sv - directed self-checking bench for psk_mod_stream (W=8, SPS=4)
module tb_psk_mod_stream;
   logic              clk = 1'b0;
   logic              rst, mode, bit_in, bit_valid, bit_ready;
   logic signed [7:0] cos_in, sin_in;
   logic              out_valid, sym_start, underrun;
   logic signed [8:0] mod_out;

   int checks = 0;
   int failures = 0;

   logic              tx_bits[16];
   logic              tx_mode[16];
   int                tx_n;
   logic              cap_v[64], cap_s[64], cap_u[64], cap_r[64];
   logic signed [8:0] cap_d[64];
   int                last_acc, n_acc;

   psk_mod_stream #(.W(8), .SPS(4)) dut (
      .clk(clk), .rst(rst), .mode(mode), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(bit_ready), .cos_in(cos_in), .sin_in(sin_in), .out_valid(out_valid),
      .mod_out(mod_out), .sym_start(sym_start), .underrun(underrun)
   );

   always #5 clk = ~clk;

   // Drive tx_bits for ncyc cycles, capturing outputs at each falling edge
   task automatic run(input int ncyc);
      int  idx;
      bit  acc;
      idx = 0; acc = 0; n_acc = 0; last_acc = -1;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (acc) begin idx++; n_acc++; last_acc = c; end
         cap_v[c] = out_valid; cap_d[c] = mod_out; cap_s[c] = sym_start;
         cap_u[c] = underrun;  cap_r[c] = bit_ready;
         if (idx < tx_n) begin
            bit_valid = 1'b1; bit_in = tx_bits[idx]; mode = tx_mode[idx];
         end else begin
            bit_valid = 1'b0;
         end
         acc = bit_valid && bit_ready;
      end
      bit_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; mode = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; cos_in = 8'sd0; sin_in = 8'sd0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (mod_out !== 9'sd0) begin failures++; $display("FAIL reset_mod_out got=%0d exp=0", mod_out); end
      checks++; if (bit_ready !== 1'b1) begin failures++; $display("FAIL reset_bit_ready got=%b exp=1", bit_ready); end
      checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
      checks++; if (sym_start !== 1'b0) begin failures++; $display("FAIL reset_sym_start got=%b exp=0", sym_start); end
      rst = 1'b0;
   endtask

   task automatic test_qpsk_single();
      int f, nv, ns, nu;
      cos_in = 8'sd100; sin_in = 8'sd20;
      tx_bits[0] = 0; tx_bits[1] = 0; tx_mode[0] = 0; tx_mode[1] = 0; tx_n = 2;
      run(12);
      f = -1; nv = 0; ns = 0; nu = 0;
      for (int c = 0; c < 12; c++) begin
         if (cap_v[c]) begin
            nv++;
            if (f < 0) f = c;
            checks++; if (cap_d[c] !== 9'sd120) begin failures++; $display("FAIL qpsk00_value cyc=%0d got=%0d exp=120", c, cap_d[c]); end
         end
         if (cap_s[c]) ns++;
         if (cap_u[c]) nu++;
      end
      checks++; if (nv != 4) begin failures++; $display("FAIL qpsk00_count got=%0d exp=4", nv); end
      checks++; if (f != last_acc + 2) begin failures++; $display("FAIL qpsk00_latency first=%0d exp=%0d", f, last_acc + 2); end
      checks++; if (ns != 1 || f < 0 || cap_s[f] !== 1'b1) begin failures++; $display("FAIL qpsk00_sym_start count=%0d exp=1", ns); end
      checks++; if (nu != 1 || f < 0 || cap_u[f+3] !== 1'b1) begin failures++; $display("FAIL qpsk00_underrun count=%0d exp=1 at last sample", nu); end
      checks++; if (f < 0 || cap_v[f+4] !== 1'b0) begin failures++; $display("FAIL qpsk00_valid_drop got=%b exp=0", (f < 0) ? 1'bx : cap_v[f+4]); end
   endtask

   task automatic check_symbol(input string name, input logic signed [8:0] exp_v, input int ncyc);
      int nv;
      run(ncyc);
      nv = 0;
      for (int c = 0; c < ncyc; c++) begin
         if (cap_v[c]) begin
            nv++;
            checks++; if (cap_d[c] !== exp_v) begin failures++; $display("FAIL %s_value cyc=%0d got=%0d exp=%0d", name, c, cap_d[c], exp_v); end
         end
      end
      checks++; if (nv != 4) begin failures++; $display("FAIL %s_count got=%0d exp=4", name, nv); end
   endtask

   task automatic test_saturation();
      cos_in = -8'sd128; sin_in = -8'sd128;
      tx_bits[0] = 1; tx_bits[1] = 1; tx_mode[0] = 0; tx_mode[1] = 0; tx_n = 2;
      check_symbol("sat_clip", 9'sd255, 12);
      tx_bits[0] = 0; tx_bits[1] = 0; tx_n = 2;
      check_symbol("sat_min", -9'sd256, 12);
   endtask

   task automatic test_back_to_back();
      logic signed [8:0] exp_v[4];
      int f, nv, nu_early, ns;
      bit saw_low;
      exp_v[0] = 9'sd120; exp_v[1] = -9'sd80; exp_v[2] = -9'sd120; exp_v[3] = 9'sd80;
      cos_in = 8'sd100; sin_in = 8'sd20;
      tx_bits[0] = 0; tx_bits[1] = 0; tx_bits[2] = 1; tx_bits[3] = 0;
      tx_bits[4] = 1; tx_bits[5] = 1; tx_bits[6] = 0; tx_bits[7] = 1;
      for (int i = 0; i < 8; i++) tx_mode[i] = 0;
      tx_n = 8;
      run(30);
      f = -1; nv = 0; ns = 0; saw_low = 0;
      for (int c = 0; c < 30; c++) begin
         if (cap_v[c]) begin nv++; if (f < 0) f = c; end
         if (cap_s[c]) ns++;
         if (!cap_r[c]) saw_low = 1;
      end
      checks++; if (nv != 16) begin failures++; $display("FAIL stream_count got=%0d exp=16", nv); end
      checks++; if (n_acc != 8) begin failures++; $display("FAIL stream_accepts got=%0d exp=8", n_acc); end
      checks++; if (!saw_low) begin failures++; $display("FAIL stream_bit_ready_low got=never exp=low while pending full"); end
      checks++; if (ns != 4) begin failures++; $display("FAIL stream_sym_start_count got=%0d exp=4", ns); end
      if (f < 0) f = 0;
      nu_early = 0;
      for (int c = 0; c < f + 15 && c < 30; c++) if (cap_u[c]) nu_early++;
      checks++; if (nu_early != 0) begin failures++; $display("FAIL stream_no_underrun got=%0d exp=0", nu_early); end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (cap_v[f+k] !== 1'b1 || cap_d[f+k] !== exp_v[k/4] || cap_s[f+k] !== (k % 4 == 0)) begin
            failures++;
            $display("FAIL stream_sample k=%0d valid=%b got=%0d exp=%0d start=%b", k, cap_v[f+k], cap_d[f+k], exp_v[k/4], cap_s[f+k]);
         end
      end
   endtask

   task automatic test_mode_bpsk();
      cos_in = 8'sd50; sin_in = 8'sd77;
      tx_bits[0] = 1; tx_mode[0] = 1; tx_n = 1;
      check_symbol("bpsk1", -9'sd50, 12);
      cos_in = 8'sd100; sin_in = 8'sd20;
      tx_bits[0] = 1; tx_bits[1] = 0; tx_mode[0] = 0; tx_mode[1] = 1; tx_n = 2;
      check_symbol("mode_mid_symbol", -9'sd80, 12);
      mode = 1'b0;
   endtask

   task automatic test_reset_mid();
      cos_in = 8'sd100; sin_in = 8'sd20;
      tx_bits[0] = 0; tx_bits[1] = 0; tx_mode[0] = 0; tx_mode[1] = 0; tx_n = 2;
      run(6);
      checks++; if (cap_v[5] !== 1'b1) begin failures++; $display("FAIL abort_pre_valid got=%b exp=1", cap_v[5]); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || mod_out !== 9'sd0) begin failures++; $display("FAIL abort_output valid=%b mod=%0d exp=0,0", out_valid, mod_out); end
      @(negedge clk);
      rst = 1'b0;
      tx_bits[0] = 0; tx_n = 1;
      run(3);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tx_bits[0] = 1; tx_bits[1] = 0; tx_n = 2;
      check_symbol("reset_partial", -9'sd80, 12);
   endtask

   initial begin
      test_reset();
      test_qpsk_single();
      test_saturation();
      test_back_to_back();
      test_mode_bpsk();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/psk_mod_stream.md
Name: psk_mod_stream

Overview:
- Parametrised successor to the fixed two-bit QPSK sample selector/adder.
- Accepts a serial bit stream through a valid/ready handshake and packs it into QPSK (2-bit) or BPSK (1-bit) symbols.
- Holds each symbol for SPS carrier samples and outputs the signed sum sI·cos + sQ·sin.
- Sits between the bit source and the DAC sample path; the carrier samples are supplied externally each clock.

Parameters:
- W, 8: width of the signed carrier samples cos_in and sin_in.
- SPS, 8: output samples per symbol; legal range ≥2.
- CNT_W, $clog2(SPS): width of the sample counter (derived; not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = QPSK, 1 = BPSK. Latched when the first bit of each symbol is accepted.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid.
- bit_ready  out  1  block can accept a bit.
- cos_in  in  W  signed in-phase carrier sample for this cycle.
- sin_in  in  W  signed quadrature carrier sample for this cycle.
- out_valid  out  1  mod_out carries a valid sample.
- mod_out  out  W+1  signed modulated sample (registered).
- sym_start  out  1  high with the first sample of each symbol.
- underrun  out  1  one-cycle pulse when a symbol ends and no next symbol is pending.

Behaviour:
- Reset:
  - out_valid=0, mod_out=0, sym_start=0, underrun=0, bit_ready=1.
  - Collector bit count=0, pending register empty, FSM=IDLE, sample counter=0, differential phase=0.
  - A partially collected symbol is discarded; reset mid-symbol aborts output on the next cycle.
- Handshake:
  - A bit is accepted on an edge where bit_valid && bit_ready.
  - bit_ready = !pend_full.
  - The collector needs 2 bits (QPSK) or 1 bit (BPSK), using the mode latched at that symbol's first bit.
  - A mode change mid-symbol is ignored until the next symbol.
  - In QPSK the first bit is b_I and the second is b_Q. In BPSK the single bit is b_I.
- Symbol completion: when the last bit of a symbol is accepted, the pending register is written and pend_full=1 from the next cycle.
- FSM states:
  - IDLE:
    - out_valid=0, mod_out=0.
    - If pend_full, load the pending symbol into the active register, clear pend_full, set counter=0 and go to RUN.
  - RUN:
    - Each cycle, register a sample and assert out_valid; counter increments.
    - At counter==SPS-1 with pend_full: load the next symbol, counter=0, stay in RUN (gapless output).
    - At counter==SPS-1 without pend_full: go to IDLE and pulse underrun on the following cycle.
    - Bits may be accepted during RUN (double buffering); a load and a new bit acceptance on the same edge are both honoured.
- Latency:
  - Last bit accepted at edge E0; symbol loaded at E1 (from IDLE); first sample registered at E2.
  - mod_out at E(n+1) uses cos_in/sin_in present in cycle n.
- Mapping:
  - Bit 0 → +1, bit 1 → −1.
  - QPSK: mod_out = sI·cos_in + sQ·sin_in.
  - BPSK: mod_out = sI·cos_in sign-extended to W+1 bits; sin_in is ignored.
- Width rule:
  - Compute in W+2 bits, then saturate to W+1 signed: max +2^W−1, min −2^W.
  - The only overflow case is −(−2^(W−1))·2 → clip to +2^W−1.
- sym_start: asserted together with out_valid on counter==0 samples only.

Optional Feature:
- Macro: PSK_DIFF_ENC_EN.
- Defined (differential encoding):
  - QPSK: Gray index per symbol: 00→0, 10→1, 11→2, 01→3. Phase = (phase + index) mod 4, updated when a symbol is loaded into the active register.
  - Phase → (sI,sQ): 0:(+,+), 1:(−,+), 2:(−,−), 3:(+,−).
  - BPSK: bit 1 toggles the sI sign state; bit 0 keeps it.
  - Phase and sign state are cleared only by rst; IDLE and underrun do not clear them.
- Undefined: absolute mapping as in Behaviour; no phase register is synthesised.

Test Plan (W=8, SPS=4):
- Reset check: assert rst 2 cycles → out_valid=0, mod_out=0, bit_ready=1, underrun=0.
- QPSK single symbol: bits 0,0; cos_in=100, sin_in=20 constant → 4 samples of 120, sym_start on the first only. out_valid then drops, underrun pulses exactly 1 cycle, and the first sample appears 2 edges after the last-bit accept.
- Saturation:
  - bits 1,1 with cos=sin=−128 → mod_out=+255 (clipped from 256).
  - bits 0,0 with cos=sin=−128 → −256, exact.
- Streaming: 4 QPSK symbols (00,10,11,01) with bit_valid held high, cos=100, sin=20 → 16 contiguous valid samples: 120×4, −80×4, −120×4, 80×4. No underrun; bit_ready low while the pending register is full.
- Mode/BPSK:
  - mode=1, bit 1, cos=50, sin=77 → −50 ×4.
  - Raising mode after the first QPSK bit still yields a QPSK symbol.
- Reset mid-operation: accept 1 QPSK bit, assert rst, then send bits 1,0 → the symbol is 10 (output −80 with cos=100, sin=20). With PSK_DIFF_ENC_EN: symbols 10,10 → phase 1 then 2 → −80 ×4 then −120 ×4.
